decode_pipe: RTL and testbench

//  Parametrised, pipelined successor of the single-cycle decode stage. It owns the register

---
 rtl/decode_pipe.sv | 152 +++++++++++++++
 tb/tb_decode_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: register file with writeback bypass, load-use hazard stall and a
// registered ID/EX bundle, with valid/ready on both the fetch and EX sides.
module decode_pipe #(
  parameter  int DATA_W   = 16,
  parameter  int INSTR_W  = 16,
  parameter  int ADDR_W   = 16,
  parameter  int NUM_REGS = 8,
  parameter  int R0_ZERO  = 0,
  localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [SEL_W-1:0]   rs_sel,
  input  logic [SEL_W-1:0]   rt_sel,
  input  logic [SEL_W-1:0]   rd_sel,
  input  logic               uses_rs,
  input  logic               uses_rt,
  input  logic               rd_wr,
  input  logic               is_load,
  input  logic               wb_en,
  input  logic [SEL_W-1:0]   wb_sel,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [INSTR_W-1:0] ex_instr,
  output logic [ADDR_W-1:0]  ex_pc,
  output logic [SEL_W-1:0]   ex_rs_sel,
  output logic [SEL_W-1:0]   ex_rt_sel,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [SEL_W-1:0]   ex_rd_sel,
  output logic               ex_rd_wr,
  output logic               ex_is_load,
  output logic               err
);

  // Storage is sized to the full select space; slots at or above NUM_REGS are
  // never written, so they stay at zero and cannot alias a real register.
  localparam int NUM_SLOTS = 2 ** SEL_W;

  logic [DATA_W-1:0]  r_regs [NUM_SLOTS];
  logic               r_ex_valid;
  logic [INSTR_W-1:0] r_ex_instr;
  logic [ADDR_W-1:0]  r_ex_pc;
  logic [SEL_W-1:0]   r_ex_rs_sel;
  logic [SEL_W-1:0]   r_ex_rt_sel;
  logic [DATA_W-1:0]  r_ex_rs_data;
  logic [DATA_W-1:0]  r_ex_rt_data;
  logic [SEL_W-1:0]   r_ex_rd_sel;
  logic               r_ex_rd_wr;
  logic               r_ex_is_load;
  logic               r_err;

  logic               w_wb_in_range;
  logic               w_wb_r0;
  logic               w_wb_commit;
  logic [DATA_W-1:0]  w_rs_data;
  logic [DATA_W-1:0]  w_rt_data;
  logic               w_hazard;
  logic               w_hold;

  assign w_wb_in_range = ({1'b0, wb_sel} < (SEL_W + 1)'(NUM_REGS));
  assign w_wb_r0       = (R0_ZERO != 0) && (wb_sel == '0);
  // A commit is the only thing that changes architectural state; bypass uses the
  // same qualifier so a dropped write is never forwarded either.
  assign w_wb_commit   = wb_en & w_wb_in_range & ~w_wb_r0;

  // Operand read with write-through from the same-cycle writeback.
  always_comb begin
    w_rs_data = r_regs[rs_sel];
    w_rt_data = r_regs[rt_sel];
    if (w_wb_commit && (wb_sel == rs_sel)) w_rs_data = wb_data;
    if (w_wb_commit && (wb_sel == rt_sel)) w_rt_data = wb_data;
  end

  assign w_hazard = r_ex_valid & r_ex_is_load & r_ex_rd_wr &
                    ((uses_rs & (rs_sel == r_ex_rd_sel)) |
                     (uses_rt & (rt_sel == r_ex_rd_sel)));
  assign w_hold   = r_ex_valid & ~ex_ready;
  assign if_ready = ~w_hold & ~w_hazard & ~flush;

  // Register file: commits regardless of flush/hold state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_regs[i] <= '0;
    end else if (w_wb_commit) begin
      r_regs[wb_sel] <= wb_data;
    end
  end

  // Out-of-range writeback flag, valid for the cycle after the attempt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= wb_en & ~w_wb_in_range;
  end

  // ID/EX bundle: flush beats hold beats load; a held bundle tracks writebacks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_instr   <= '0;
      r_ex_pc      <= '0;
      r_ex_rs_sel  <= '0;
      r_ex_rt_sel  <= '0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_rd_sel  <= '0;
      r_ex_rd_wr   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else if (flush) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd_wr   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else if (w_hold) begin
      if (w_wb_commit && (wb_sel == r_ex_rs_sel)) r_ex_rs_data <= wb_data;
      if (w_wb_commit && (wb_sel == r_ex_rt_sel)) r_ex_rt_data <= wb_data;
    end else if (if_valid && if_ready) begin
      r_ex_valid   <= 1'b1;
      r_ex_instr   <= if_instr;
      r_ex_pc      <= if_pc;
      r_ex_rs_sel  <= rs_sel;
      r_ex_rt_sel  <= rt_sel;
      r_ex_rs_data <= w_rs_data;
      r_ex_rt_data <= w_rt_data;
      r_ex_rd_sel  <= rd_sel;
      r_ex_rd_wr   <= rd_wr;
      r_ex_is_load <= is_load;
    end else begin
      r_ex_valid   <= 1'b0;
      r_ex_rd_wr   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_instr   = r_ex_instr;
  assign ex_pc      = r_ex_pc;
  assign ex_rs_sel  = r_ex_rs_sel;
  assign ex_rt_sel  = r_ex_rt_sel;
  assign ex_rs_data = r_ex_rs_data;
  assign ex_rt_data = r_ex_rt_data;
  assign ex_rd_sel  = r_ex_rd_sel;
  assign ex_rd_wr   = r_ex_rd_wr;
  assign ex_is_load = r_ex_is_load;
  assign err        = r_err;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe (NUM_REGS=6, R0_ZERO=1) with an expected-bundle queue.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [15:0] if_instr, if_pc;
  logic [2:0]  rs_sel, rt_sel, rd_sel;
  logic        uses_rs, uses_rt, rd_wr, is_load;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [15:0] ex_instr, ex_pc, ex_rs_data, ex_rt_data;
  logic [2:0]  ex_rs_sel, ex_rt_sel, ex_rd_sel;
  logic        ex_rd_wr, ex_is_load, err;

  always #5 clk = ~clk;

  decode_pipe #(.DATA_W(16), .INSTR_W(16), .ADDR_W(16), .NUM_REGS(6), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .rd_sel(rd_sel),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .rd_wr(rd_wr), .is_load(is_load),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rs_sel(ex_rs_sel), .ex_rt_sel(ex_rt_sel),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rd_sel(ex_rd_sel), .ex_rd_wr(ex_rd_wr), .ex_is_load(ex_is_load), .err(err)
  );

  typedef struct {
    logic [15:0] instr, pc, rs_data, rt_data;
    logic [2:0]  rs_sel, rt_sel, rd_sel;
    logic        rd_wr, is_load;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_regs [8];
  bit          just_pushed = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wb_commits();
    return wb_en && (wb_sel < 3'd6) && (wb_sel != 3'd0);
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] sel);
    if (sel == 3'd0) return 16'h0;
    if (wb_commits() && wb_sel == sel) return wb_data;
    return m_regs[sel];
  endfunction

  task automatic idle();
    if_valid = 0; if_instr = 0; if_pc = 0;
    rs_sel = 0; rt_sel = 0; rd_sel = 0;
    uses_rs = 0; uses_rt = 0; rd_wr = 0; is_load = 0;
    wb_en = 0; wb_sel = 0; wb_data = 0; flush = 0; ex_ready = 1;
  endtask

  task automatic wb(input logic [2:0] sel, input logic [15:0] data);
    wb_en = 1; wb_sel = sel; wb_data = data;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] pc,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic urs, input logic urt, input logic rdw, input logic ld,
                       input logic acc, input string tag);
    exp_t e;
    if_valid = 1; if_instr = ins; if_pc = pc;
    rs_sel = rs; rt_sel = rt; rd_sel = rd;
    uses_rs = urs; uses_rt = urt; rd_wr = rdw; is_load = ld;
    #1;
    chk({tag, "_if_ready"}, 64'(if_ready), 64'(acc));
    if (acc) begin
      e.instr = ins; e.pc = pc; e.rs_sel = rs; e.rt_sel = rt; e.rd_sel = rd;
      e.rs_data = exp_rd(rs); e.rt_data = exp_rd(rt);
      e.rd_wr = rdw; e.is_load = ld;
      q.push_back(e);
      just_pushed = 1'b1;
    end
  endtask

  // Advance one clock, applying the expected effect of this cycle's flush/hold/writeback.
  task automatic cycle();
    exp_t e;
    if (flush) begin
      if (q.size() > 0) void'(q.pop_front());
    end else if ((q.size() > (just_pushed ? 1 : 0)) && !ex_ready) begin
      e = q.pop_front();
      if (wb_commits() && e.rs_sel == wb_sel) e.rs_data = wb_data;
      if (wb_commits() && e.rt_sel == wb_sel) e.rt_data = wb_data;
      q.push_front(e);
    end
    if (wb_commits()) m_regs[wb_sel] = wb_data;
    just_pushed = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each bundle EX consumes is checked against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && !flush && ex_valid && ex_ready) begin
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=%0h expected=queued_entry", ex_instr);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_instr_pc", {ex_instr, ex_pc}, {e.instr, e.pc});
        chk("sb_sels", {ex_rs_sel, ex_rt_sel, ex_rd_sel}, {e.rs_sel, e.rt_sel, e.rd_sel});
        chk("sb_rs_data", 64'(ex_rs_data), 64'(e.rs_data));
        chk("sb_rt_data", 64'(ex_rt_data), 64'(e.rt_data));
        chk("sb_flags", {ex_rd_wr, ex_is_load}, {e.rd_wr, e.is_load});
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 64'(ex_valid), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_flags", {ex_rd_wr, ex_is_load}, 0);
    chk("rst_if_ready", 64'(if_ready), 1);
    rst = 1;

    idle(); wb(3'd1, 16'h1111); cycle();
    idle(); wb(3'd2, 16'h2222); cycle();
    idle(); wb(3'd4, 16'h4444); cycle();
    chk("wb_err_low", 64'(err), 0);

    // same-cycle bypass, then back-to-back issue
    idle(); wb(3'd3, 16'h1234);
    issue(16'hA003, 16'h0102, 3'd3, 3'd1, 3'd5, 1, 1, 1, 0, 1, "byp"); cycle();
    chk("byp_latency_valid", 64'(ex_valid), 1);
    chk("byp_rs_data", 64'(ex_rs_data), 64'h1234);
    idle(); issue(16'hA004, 16'h0104, 3'd4, 3'd2, 3'd5, 1, 1, 1, 0, 1, "b2b"); cycle();

    // load-use: one bubble
    idle(); issue(16'hC002, 16'h0106, 3'd1, 3'd0, 3'd2, 1, 0, 1, 1, 1, "ld"); cycle();
    idle(); issue(16'hD020, 16'h0108, 3'd2, 3'd3, 3'd4, 1, 1, 1, 0, 0, "ldu_stall"); cycle();
    chk("ldu_bubble_valid", 64'(ex_valid), 0);
    chk("ldu_bubble_flags", {ex_rd_wr, ex_is_load}, 0);
    idle(); issue(16'hD020, 16'h0108, 3'd2, 3'd3, 3'd4, 1, 1, 1, 0, 1, "ldu_go"); cycle();
    chk("ldu_valid", 64'(ex_valid), 1);

    // matching select without the use flag is not a hazard
    idle(); issue(16'hC005, 16'h010A, 3'd1, 3'd0, 3'd5, 1, 0, 1, 1, 1, "ld5"); cycle();
    idle(); issue(16'hE050, 16'h010C, 3'd5, 3'd1, 3'd3, 0, 1, 1, 0, 1, "no_use"); cycle();

    // backpressure for three cycles with a writeback to the held rt
    idle(); issue(16'hB041, 16'h0110, 3'd4, 3'd1, 3'd3, 1, 1, 1, 0, 1, "bp"); cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); ex_ready = 0;
      if (k == 0) wb(3'd1, 16'hBEEF);
      issue(16'hB999, 16'h0112, 3'd2, 3'd2, 3'd2, 1, 1, 1, 0, 0, "bp_hold");
      cycle();
      chk("bp_valid", 64'(ex_valid), 1);
      chk("bp_instr", 64'(ex_instr), 64'hB041);
      chk("bp_rt_data", 64'(ex_rt_data), 64'hBEEF);
    end
    idle(); issue(16'hB999, 16'h0112, 3'd2, 3'd2, 3'd2, 1, 1, 1, 0, 1, "bp_go"); cycle();

    // flush while held; writeback in the same cycle still commits
    idle(); ex_ready = 0; flush = 1; wb(3'd4, 16'h5A5A);
    issue(16'hF000, 16'h0120, 3'd1, 3'd1, 3'd1, 1, 1, 1, 0, 0, "fl"); cycle();
    chk("fl_valid", 64'(ex_valid), 0);
    idle(); issue(16'hF004, 16'h0122, 3'd4, 3'd0, 3'd1, 1, 1, 1, 0, 1, "fl_after"); cycle();

    // range: sel 7 and 6 out of range, 5 is the last real register
    idle(); wb(3'd7, 16'hDEAD); cycle();
    chk("rng7_err", 64'(err), 1);
    idle(); cycle();
    chk("rng_err_one_cycle", 64'(err), 0);
    idle(); wb(3'd6, 16'hDEAD); cycle();
    chk("rng6_err", 64'(err), 1);
    idle(); wb(3'd5, 16'h5555); cycle();
    chk("rng5_err", 64'(err), 0);
    for (int i = 1; i < 6; i++) begin
      idle(); issue(16'h1000 + 16'(i), 16'h0140, 3'(i), 3'(i), 3'd0, 1, 1, 0, 0, 1, "rd_back");
      cycle();
    end

    // r0 stays zero, including through the bypass path
    idle(); wb(3'd0, 16'hFFFF);
    issue(16'h0F00, 16'h0150, 3'd0, 3'd0, 3'd0, 1, 1, 0, 0, 1, "r0_byp"); cycle();
    chk("r0_byp_rs", 64'(ex_rs_data), 0);
    idle(); issue(16'h0F01, 16'h0152, 3'd0, 3'd0, 3'd0, 1, 1, 0, 0, 1, "r0_read"); cycle();
    idle(); cycle();

    // asynchronous reset with a held bundle and err set
    idle(); ex_ready = 0; wb(3'd7, 16'h0001);
    issue(16'h7777, 16'h0130, 3'd1, 3'd2, 3'd3, 1, 1, 1, 1, 1, "pre_rst"); cycle();
    chk("pre_rst_valid", 64'(ex_valid), 1);
    chk("pre_rst_err", 64'(err), 1);
    #2 rst = 0;
    #1;
    chk("mid_rst_valid", 64'(ex_valid), 0);
    chk("mid_rst_err", 64'(err), 0);
    chk("mid_rst_flags", {ex_rd_wr, ex_is_load}, 0);
    q.delete();
    just_pushed = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    idle();
    @(posedge clk);
    #1;
    rst = 1;
    for (int i = 1; i < 6; i++) begin
      idle(); issue(16'h2000 + 16'(i), 16'h0160, 3'(i), 3'(i), 3'd0, 1, 1, 0, 0, 1, "post_rst");
      cycle();
      chk("post_rst_rs", 64'(ex_rs_data), 0);
    end
    idle(); cycle();
    idle(); cycle();
    chk("sb_drained", 64'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
